sdram_port_scheduler: RTL and testbench

SDRAM_PORT_SCHEDULER -- requirements
Module: sdram_port_scheduler

---
 rtl/sdram_sched_pkg.sv | 23 ++
 rtl/sdram_port_scheduler_if.sv | 29 ++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/sdram_port_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_sdram_port_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared definitions for the SDRAM port scheduler.
// Holds the sequencer command encodings, the scheduler FSM state encoding
// and the default address / burst-length / FIFO-fill widths.
package sdram_sched_pkg;

    localparam int unsigned DEF_ASIZE = 23;
    localparam int unsigned DEF_LW    = 9;
    localparam int unsigned DEF_UW    = 16;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_RD   = 2'b01,
        CMD_WR   = 2'b10
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_BUSY   = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

endpackage

// File: rtl/sdram_port_scheduler_if.sv
// Scheduler <-> SDRAM sequencer command handshake.
//   CMD       : 00 idle, 01 read, 10 write (scheduler -> sequencer)
//   CMD_ADDR  : burst start word address   (scheduler -> sequencer)
//   CMD_LEN   : burst length               (scheduler -> sequencer)
//   CMD_ACK   : sequencer accepted CMD     (sequencer -> scheduler)
//   XFER_DONE : one-cycle pulse at burst end (sequencer -> scheduler)
// master = scheduler side, slave = sequencer side.
interface sdram_port_scheduler_if
    import sdram_sched_pkg::*;
#(
    parameter int unsigned ASIZE = DEF_ASIZE,
    parameter int unsigned LW    = DEF_LW
);
    logic [1:0]       CMD;
    logic [ASIZE-1:0] CMD_ADDR;
    logic [LW-1:0]    CMD_LEN;
    logic             CMD_ACK;
    logic             XFER_DONE;

    modport master (
        output CMD, CMD_ADDR, CMD_LEN,
        input  CMD_ACK, XFER_DONE
    );

    modport slave (
        input  CMD, CMD_ADDR, CMD_LEN,
        output CMD_ACK, XFER_DONE
    );
endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : N request lines
//   advance    : a grant is being taken this cycle; rotate past it
//   gnt        : one-hot combinational grant (zero when no request)
// The search starts at start_q, which holds the index after the last
// taken grant (0 out of reset).
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] start_q, start_d;
    logic          found;
    int unsigned   gidx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        gidx  = 0;
        // first pass: indices at or above the start point
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(start_q))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gidx   = i;
            end
        end
        // second pass wraps around to the indices below the start point
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gidx   = i;
            end
        end
        start_d = start_q;
        if (advance && found) begin
            start_d = (gidx == N - 1) ? '0 : IW'(gidx + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
        end else begin
            start_q <= start_d;
        end
    end
endmodule

// File: rtl/sdram_port_scheduler.sv
// Multi-port SDRAM burst scheduler.
// Picks one eligible FIFO port at a time, issues a burst command to the
// sequencer, gates that port's FIFO with a one-hot grant for the whole burst
// and then advances the port's circular address pointer.
//   CLK, RESET_N             : clock, asynchronous active-low reset
//   WR_BASE/MAX/LEN/LOAD/USED: per write-port window, burst length, pointer
//                              reload, write-FIFO read-side fill
//   RD_BASE/MAX/LEN/LOAD/USED: read-port equivalents (RD_USED = write-side fill)
//   WR_GNT, RD_GNT           : one-hot active port
//   BUSY                     : FSM not idle
//   seq                      : command handshake to the sequencer
module sdram_port_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int unsigned NWR     = 2,
    parameter int unsigned NRD     = 2,
    parameter int unsigned ASIZE   = DEF_ASIZE,
    parameter int unsigned LW      = DEF_LW,
    parameter int unsigned UW      = DEF_UW,
    parameter int unsigned RD_PRIO = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [NWR*ASIZE-1:0]  WR_BASE,
    input  logic [NWR*ASIZE-1:0]  WR_MAX,
    input  logic [NWR*LW-1:0]     WR_LEN,
    input  logic [NWR-1:0]        WR_LOAD,
    input  logic [NWR*UW-1:0]     WR_USED,
    input  logic [NRD*ASIZE-1:0]  RD_BASE,
    input  logic [NRD*ASIZE-1:0]  RD_MAX,
    input  logic [NRD*LW-1:0]     RD_LEN,
    input  logic [NRD-1:0]        RD_LOAD,
    input  logic [NRD*UW-1:0]     RD_USED,
    output logic [NWR-1:0]        WR_GNT,
    output logic [NRD-1:0]        RD_GNT,
    output logic                  BUSY,
    sdram_port_scheduler_if.master seq
);
    // Ports are handled as one vector: reads 0..NRD-1, then writes.
    localparam int unsigned NT  = NRD + NWR;
    localparam int unsigned CW  = (UW > LW) ? UW : LW;
    localparam int unsigned AW1 = ASIZE + 1;

    logic [ASIZE-1:0] base_a  [NT];
    logic [ASIZE-1:0] max_a   [NT];
    logic [ASIZE-1:0] eff_ptr [NT];
    logic [LW-1:0]    len_a   [NT];
    logic [UW-1:0]    used_a  [NT];
    logic [NT-1:0]    load_v;
    logic [NT-1:0]    elig;
    logic [NT-1:0]    req_gnt;

    state_e           state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [ASIZE-1:0] addr_q, addr_d, sel_addr;
    logic [LW-1:0]    len_q, len_d, sel_len;
    logic [NT-1:0]    gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             arb_go;

    for (genvar j = 0; j < NRD; j++) begin : g_rd_map
        assign base_a[j] = RD_BASE[j*ASIZE +: ASIZE];
        assign max_a[j]  = RD_MAX[j*ASIZE +: ASIZE];
        assign len_a[j]  = RD_LEN[j*LW +: LW];
        assign used_a[j] = RD_USED[j*UW +: UW];
        assign load_v[j] = RD_LOAD[j];
        // read FIFO must have room for a whole burst
        assign elig[j]   = (len_a[j] != '0) && !load_v[j] &&
                           (CW'(used_a[j]) < CW'(len_a[j]));
    end

    for (genvar i = 0; i < NWR; i++) begin : g_wr_map
        assign base_a[NRD+i] = WR_BASE[i*ASIZE +: ASIZE];
        assign max_a[NRD+i]  = WR_MAX[i*ASIZE +: ASIZE];
        assign len_a[NRD+i]  = WR_LEN[i*LW +: LW];
        assign used_a[NRD+i] = WR_USED[i*UW +: UW];
        assign load_v[NRD+i] = WR_LOAD[i];
        // write FIFO must already hold a whole burst
        assign elig[NRD+i]   = (len_a[NRD+i] != '0) && !load_v[NRD+i] &&
                               (CW'(used_a[NRD+i]) >= CW'(len_a[NRD+i]));
    end

    assign arb_go = (state_q == ST_IDLE);

    if (RD_PRIO != 0) begin : g_prio
        logic [NRD-1:0] rd_g;
        logic [NWR-1:0] wr_g;
        logic           rd_any;

        assign rd_any = |elig[NRD-1:0];

        rr_arbiter #(.N(NRD)) u_rd_arb (
            .clk     (CLK),
            .rst_n   (RESET_N),
            .req     (elig[NRD-1:0]),
            .advance (arb_go && rd_any),
            .gnt     (rd_g)
        );

        rr_arbiter #(.N(NWR)) u_wr_arb (
            .clk     (CLK),
            .rst_n   (RESET_N),
            .req     (elig[NT-1:NRD]),
            .advance (arb_go && !rd_any),
            .gnt     (wr_g)
        );

        assign req_gnt = rd_any ? {{NWR{1'b0}}, rd_g} : {wr_g, {NRD{1'b0}}};
    end else begin : g_flat
        rr_arbiter #(.N(NT)) u_arb (
            .clk     (CLK),
            .rst_n   (RESET_N),
            .req     (elig),
            .advance (arb_go),
            .gnt     (req_gnt)
        );
    end

    // Per-port pointers. The async reset only clears vld_q; until the first
    // clock the pointer reads as BASE, which avoids an async load from a
    // non-constant input while keeping the "reset loads BASE" behaviour.
    for (genvar p = 0; p < NT; p++) begin : g_ptr
        logic [ASIZE-1:0] ptr_q, ptr_d;
        logic             vld_q;
        logic [ASIZE:0]   room;
        logic [ASIZE:0]   cur;

        always_comb begin
            cur   = {1'b0, eff_ptr[p]};
            // MAX-LEN at ASIZE+1 bits; top bit set means MAX < LEN
            room  = {1'b0, max_a[p]} - AW1'(len_a[p]);
            ptr_d = eff_ptr[p];
            if (load_v[p]) begin
                ptr_d = base_a[p];
            end else if ((state_q == ST_UPDATE) && gnt_q[p]) begin
                if (!room[ASIZE] && (cur < room)) begin
                    ptr_d = eff_ptr[p] + ASIZE'(len_a[p]);
                end else begin
                    ptr_d = base_a[p];
                end
            end
        end

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                ptr_q <= '0;
                vld_q <= 1'b0;
            end else begin
                ptr_q <= ptr_d;
                vld_q <= 1'b1;
            end
        end

        assign eff_ptr[p] = vld_q ? ptr_q : base_a[p];
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        len_d    = len_q;
        gnt_d    = gnt_q;
        sel_addr = '0;
        sel_len  = '0;
        for (int unsigned p = 0; p < NT; p++) begin
            if (req_gnt[p]) begin
                sel_addr = sel_addr | eff_ptr[p];
                sel_len  = sel_len | len_a[p];
            end
        end
        unique case (state_q)
            ST_IDLE: begin
                if (|req_gnt) begin
                    state_d = ST_ISSUE;
                    cmd_d   = (|req_gnt[NRD-1:0]) ? CMD_RD : CMD_WR;
                    addr_d  = sel_addr;
                    len_d   = sel_len;
                    gnt_d   = req_gnt;
                end
            end
            ST_ISSUE: begin
                if (seq.CMD_ACK) begin
                    cmd_d   = CMD_IDLE;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (seq.XFER_DONE) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    assign seq.CMD      = cmd_q;
    assign seq.CMD_ADDR = addr_q;
    assign seq.CMD_LEN  = len_q;
    assign RD_GNT       = gnt_q[NRD-1:0];
    assign WR_GNT       = gnt_q[NT-1:NRD];
    assign BUSY         = busy_q;
endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Self-checking bench for sdram_port_scheduler.
// Two instances share the port configuration inputs: dut_p (RD_PRIO=1)
// and dut_r (RD_PRIO=0), each with its own sequencer handshake.
module tb_sdram_port_scheduler;
    import sdram_sched_pkg::*;

    localparam int unsigned NWR = 2, NRD = 2, ASIZE = 23, LW = 9, UW = 16;

    typedef struct packed {
        logic [1:0]       cmd;
        logic [ASIZE-1:0] addr;
        logic [LW-1:0]    len;
        logic [3:0]       gnt;   // {WR_GNT, RD_GNT}
    } exp_t;

    logic CLK = 1'b0;
    logic RESET_N;
    always #5 CLK = ~CLK;

    logic [NWR*ASIZE-1:0] WR_BASE, WR_MAX;
    logic [NWR*LW-1:0]    WR_LEN;
    logic [NWR-1:0]       WR_LOAD;
    logic [NWR*UW-1:0]    WR_USED;
    logic [NRD*ASIZE-1:0] RD_BASE, RD_MAX;
    logic [NRD*LW-1:0]    RD_LEN;
    logic [NRD-1:0]       RD_LOAD;
    logic [NRD*UW-1:0]    RD_USED;
    logic [NWR-1:0]       p_wr_gnt, r_wr_gnt;
    logic [NRD-1:0]       p_rd_gnt, r_rd_gnt;
    logic                 p_busy, r_busy;

    sdram_port_scheduler_if #(.ASIZE(ASIZE), .LW(LW)) if_p ();
    sdram_port_scheduler_if #(.ASIZE(ASIZE), .LW(LW)) if_r ();

    sdram_port_scheduler #(
        .NWR(NWR), .NRD(NRD), .ASIZE(ASIZE), .LW(LW), .UW(UW), .RD_PRIO(1)
    ) dut_p (
        .CLK(CLK), .RESET_N(RESET_N),
        .WR_BASE(WR_BASE), .WR_MAX(WR_MAX), .WR_LEN(WR_LEN),
        .WR_LOAD(WR_LOAD), .WR_USED(WR_USED),
        .RD_BASE(RD_BASE), .RD_MAX(RD_MAX), .RD_LEN(RD_LEN),
        .RD_LOAD(RD_LOAD), .RD_USED(RD_USED),
        .WR_GNT(p_wr_gnt), .RD_GNT(p_rd_gnt), .BUSY(p_busy),
        .seq(if_p)
    );

    sdram_port_scheduler #(
        .NWR(NWR), .NRD(NRD), .ASIZE(ASIZE), .LW(LW), .UW(UW), .RD_PRIO(0)
    ) dut_r (
        .CLK(CLK), .RESET_N(RESET_N),
        .WR_BASE(WR_BASE), .WR_MAX(WR_MAX), .WR_LEN(WR_LEN),
        .WR_LOAD(WR_LOAD), .WR_USED(WR_USED),
        .RD_BASE(RD_BASE), .RD_MAX(RD_MAX), .RD_LEN(RD_LEN),
        .RD_LOAD(RD_LOAD), .RD_USED(RD_USED),
        .WR_GNT(r_wr_gnt), .RD_GNT(r_rd_gnt), .BUSY(r_busy),
        .seq(if_r)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    exp_t        exp_q[$];

    function automatic exp_t sample(input bit sel);
        exp_t s;
        if (sel) begin
            s.cmd = if_r.CMD; s.addr = if_r.CMD_ADDR; s.len = if_r.CMD_LEN;
            s.gnt = {r_wr_gnt, r_rd_gnt};
        end else begin
            s.cmd = if_p.CMD; s.addr = if_p.CMD_ADDR; s.len = if_p.CMD_LEN;
            s.gnt = {p_wr_gnt, p_rd_gnt};
        end
        return s;
    endfunction

    task automatic push_exp(input logic [1:0] c, input logic [ASIZE-1:0] a,
                            input logic [LW-1:0] l, input logic [3:0] g);
        exp_t e;
        e.cmd = c; e.addr = a; e.len = l; e.gnt = g;
        exp_q.push_back(e);
    endtask

    task automatic clear_cfg();
        WR_BASE = '0; WR_MAX = '0; WR_LEN = '0; WR_LOAD = '0; WR_USED = '0;
        RD_BASE = '0; RD_MAX = '0; RD_LEN = '0; RD_LOAD = '0; RD_USED = '0;
    endtask

    task automatic set_rd(input int unsigned j, input logic [ASIZE-1:0] base,
                          input logic [ASIZE-1:0] max, input logic [LW-1:0] len,
                          input logic [UW-1:0] used);
        RD_BASE[j*ASIZE +: ASIZE] = base;
        RD_MAX[j*ASIZE +: ASIZE]  = max;
        RD_LEN[j*LW +: LW]        = len;
        RD_USED[j*UW +: UW]       = used;
    endtask

    task automatic set_wr(input int unsigned j, input logic [ASIZE-1:0] base,
                          input logic [ASIZE-1:0] max, input logic [LW-1:0] len,
                          input logic [UW-1:0] used);
        WR_BASE[j*ASIZE +: ASIZE] = base;
        WR_MAX[j*ASIZE +: ASIZE]  = max;
        WR_LEN[j*LW +: LW]        = len;
        WR_USED[j*UW +: UW]       = used;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        if_p.CMD_ACK = 1'b0; if_p.XFER_DONE = 1'b0;
        if_r.CMD_ACK = 1'b0; if_r.XFER_DONE = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    // Acts as the sequencer for one burst: waits (bounded) for a command,
    // optionally stalls the ack, acks it, and optionally raises XFER_DONE
    // (left high; the next wait clears it, making a one-cycle pulse).
    task automatic serve(input bit sel, input int unsigned ack_delay, input bit do_done,
                         output bit seen, output int unsigned waited, output bit stable,
                         output exp_t obs, output logic [1:0] cmd_after);
        exp_t cur;
        seen = 1'b0; waited = 0; stable = 1'b1; cmd_after = 2'b11;
        obs = '0;
        while (!seen && waited < 60) begin
            @(negedge CLK);
            waited++;
            if_p.XFER_DONE = 1'b0;
            if_r.XFER_DONE = 1'b0;
            cur = sample(sel);
            if (cur.cmd != 2'b00) seen = 1'b1;
        end
        if (!seen) return;
        obs = cur;
        repeat (ack_delay) begin
            @(negedge CLK);
            cur = sample(sel);
            if (cur !== obs) stable = 1'b0;
        end
        if (sel) if_r.CMD_ACK = 1'b1; else if_p.CMD_ACK = 1'b1;
        @(negedge CLK);
        if_p.CMD_ACK = 1'b0;
        if_r.CMD_ACK = 1'b0;
        cur = sample(sel);
        cmd_after = cur.cmd;
        if (do_done) begin
            @(negedge CLK);
            if (sel) if_r.XFER_DONE = 1'b1; else if_p.XFER_DONE = 1'b1;
        end
    endtask

    task automatic test_reset();
        exp_t s;
        clear_cfg();
        RESET_N = 1'b0;
        if_p.CMD_ACK = 1'b0; if_p.XFER_DONE = 1'b0;
        if_r.CMD_ACK = 1'b0; if_r.XFER_DONE = 1'b0;
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            s = sample(k[0]);
            n_checks++;
            if (s !== exp_t'(0)) $display("FAIL reset_outputs dut%0d: got %h want 0", k, s);
            else n_pass++;
        end
        n_checks++;
        if ({p_busy, r_busy} !== 2'b00) $display("FAIL reset_busy: got %b want 00", {p_busy, r_busy});
        else n_pass++;
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({p_busy, r_busy, if_p.CMD, if_r.CMD} !== 6'b0)
            $display("FAIL idle_no_elig: got busy=%b%b cmd=%b/%b want all 0", p_busy, r_busy, if_p.CMD, if_r.CMD);
        else n_pass++;
    endtask

    task automatic test_read_first();
        bit seen, stable; int unsigned w; exp_t obs, e; logic [1:0] ca;
        clear_cfg();
        set_rd(0, 23'h1000, 23'h100000, 9'd256, 16'd0);
        set_wr(0, 23'h2000, 23'h100000, 9'd256, 16'd300);
        push_exp(CMD_RD, 23'h1000, 9'd256, 4'b0001);
        push_exp(CMD_WR, 23'h2000, 9'd256, 4'b0100);
        do_reset();
        serve(1'b0, 0, 1'b1, seen, w, stable, obs, ca);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen) $display("FAIL read_first_timeout: no command within bound");
        else n_pass++;
        n_checks++;
        if (obs !== e) $display("FAIL read_first_cmd: got %h want %h", obs, e);
        else n_pass++;
        n_checks++;
        if (w !== 1) $display("FAIL grant_latency: got %0d want 1", w);
        else n_pass++;
        n_checks++;
        if (ca !== 2'b00) $display("FAIL cmd_after_ack: got %b want 00", ca);
        else n_pass++;
        set_rd(0, 23'h1000, 23'h100000, 9'd256, 16'd256);
        serve(1'b0, 0, 1'b1, seen, w, stable, obs, ca);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen || obs !== e) $display("FAIL write_after_read: seen=%0d got %h want %h", seen, obs, e);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit seen, stable; int unsigned w; exp_t obs, e; logic [1:0] ca;
        clear_cfg();
        set_wr(0, 23'h0, 23'd1024, 9'd256, 16'd300);
        push_exp(CMD_WR, 23'd0,   9'd256, 4'b0100);
        push_exp(CMD_WR, 23'd256, 9'd256, 4'b0100);
        push_exp(CMD_WR, 23'd512, 9'd256, 4'b0100);
        push_exp(CMD_WR, 23'd768, 9'd256, 4'b0100);
        push_exp(CMD_WR, 23'd0,   9'd256, 4'b0100);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            serve(1'b0, 0, 1'b1, seen, w, stable, obs, ca);
            e = exp_q.pop_front();
            n_checks++;
            if (!seen || obs !== e) $display("FAIL wrap_burst%0d: seen=%0d got addr=%0d want addr=%0d (got %h want %h)", k, seen, obs.addr, e.addr, obs, e);
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (w !== 3) $display("FAIL turnaround%0d: got %0d cycles want 3", k, w);
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        bit seen, stable; int unsigned w; exp_t obs, e; logic [1:0] ca;
        clear_cfg();
        set_rd(0, 23'h10000, 23'h400000, 9'd256, 16'd0);
        set_rd(1, 23'h20000, 23'h400000, 9'd256, 16'd0);
        set_wr(0, 23'h30000, 23'h400000, 9'd256, 16'd300);
        set_wr(1, 23'h40000, 23'h400000, 9'd256, 16'd300);
        push_exp(CMD_RD, 23'h10000, 9'd256, 4'b0001);
        push_exp(CMD_RD, 23'h20000, 9'd256, 4'b0010);
        push_exp(CMD_WR, 23'h30000, 9'd256, 4'b0100);
        push_exp(CMD_WR, 23'h40000, 9'd256, 4'b1000);
        push_exp(CMD_RD, 23'h10100, 9'd256, 4'b0001);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            serve(1'b1, 0, 1'b1, seen, w, stable, obs, ca);
            e = exp_q.pop_front();
            n_checks++;
            if (!seen || obs !== e) $display("FAIL rr_grant%0d: seen=%0d got gnt=%b addr=%h want gnt=%b addr=%h", k, seen, obs.gnt, obs.addr, e.gnt, e.addr);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        bit seen, stable; int unsigned w; exp_t obs, e; logic [1:0] ca;
        clear_cfg();
        set_wr(0, 23'h500, 23'h100000, 9'd100, 16'd300);
        push_exp(CMD_WR, 23'h500, 9'd100, 4'b0100);
        do_reset();
        serve(1'b0, 20, 1'b1, seen, w, stable, obs, ca);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen || obs !== e) $display("FAIL stall_cmd: seen=%0d got %h want %h", seen, obs, e);
        else n_pass++;
        n_checks++;
        if (stable !== 1'b1) $display("FAIL stall_stable: got %0d want 1", stable);
        else n_pass++;
        n_checks++;
        if (ca !== 2'b00) $display("FAIL stall_cmd_after_ack: got %b want 00", ca);
        else n_pass++;
    endtask

    task automatic test_load_race();
        bit seen, stable; int unsigned w; exp_t obs, e; logic [1:0] ca;
        clear_cfg();
        set_rd(1, 23'h7000, 23'h100000, 9'd256, 16'd0);
        push_exp(CMD_RD, 23'h7000, 9'd256, 4'b0010);
        push_exp(CMD_RD, 23'h7000, 9'd256, 4'b0010);
        push_exp(CMD_RD, 23'h7100, 9'd256, 4'b0010);
        do_reset();
        serve(1'b0, 0, 1'b1, seen, w, stable, obs, ca);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen || obs !== e) $display("FAIL race_first: seen=%0d got %h want %h", seen, obs, e);
        else n_pass++;
        // DUT is now in UPDATE for rd1; reload collides with the advance
        @(negedge CLK);
        if_p.XFER_DONE = 1'b0;
        RD_LOAD[1] = 1'b1;
        @(negedge CLK);
        RD_LOAD[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            serve(1'b0, 0, 1'b1, seen, w, stable, obs, ca);
            e = exp_q.pop_front();
            n_checks++;
            if (!seen || obs.addr !== e.addr) $display("FAIL race_after%0d: seen=%0d got addr=%h want %h", k, seen, obs.addr, e.addr);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_busy();
        bit seen, stable; int unsigned w; exp_t obs, e; logic [1:0] ca;
        clear_cfg();
        set_wr(0, 23'h800, 23'h100000, 9'd16, 16'd300);
        push_exp(CMD_WR, 23'h800, 9'd16, 4'b0100);
        push_exp(CMD_WR, 23'h810, 9'd16, 4'b0100);
        push_exp(CMD_WR, 23'h800, 9'd16, 4'b0100);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            serve(1'b0, 0, (k == 0), seen, w, stable, obs, ca);
            e = exp_q.pop_front();
            n_checks++;
            if (!seen || obs !== e) $display("FAIL midbusy_pre%0d: seen=%0d got %h want %h", k, seen, obs, e);
            else n_pass++;
        end
        n_checks++;
        if (p_busy !== 1'b1) $display("FAIL midbusy_in_busy: got %b want 1", p_busy);
        else n_pass++;
        @(negedge CLK);
        RESET_N = 1'b0;
        set_wr(0, 23'h800, 23'h100000, 9'd16, 16'd0);
        @(negedge CLK);
        obs = sample(1'b0);
        n_checks++;
        if (obs !== exp_t'(0) || p_busy !== 1'b0) $display("FAIL midbusy_reset_outputs: got %h busy=%b want 0", obs, p_busy);
        else n_pass++;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        if_p.XFER_DONE = 1'b1;
        @(negedge CLK);
        if_p.XFER_DONE = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (p_busy !== 1'b0 || p_wr_gnt !== 2'b00) $display("FAIL stray_done: got busy=%b gnt=%b want 0/00", p_busy, p_wr_gnt);
        else n_pass++;
        set_wr(0, 23'h800, 23'h100000, 9'd16, 16'd300);
        serve(1'b0, 0, 1'b1, seen, w, stable, obs, ca);
        e = exp_q.pop_front();
        n_checks++;
        if (!seen || obs.addr !== e.addr) $display("FAIL midbusy_ptr_base: seen=%0d got addr=%h want %h", seen, obs.addr, e.addr);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_first();
        test_wrap();
        test_round_robin();
        test_stall();
        test_load_race();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
